// File: rtl/aes128_decrypt_iter_if.sv
// Handshake and data bundle for the iterative AES-128 decryptor.
// master: request/response side (drives key, ciphertext, in_valid, out_ready).
// slave:  the core (drives in_ready, out_valid, plaintext, busy).
interface aes128_decrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  modport master (
    output in_valid, key, ciphertext, out_ready,
    input  in_ready, out_valid, plaintext, busy
  );

  modport slave (
    input  in_valid, key, ciphertext, out_ready,
    output in_ready, out_valid, plaintext, busy
  );
endinterface

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, forward key expansion cached.
// Latency: 21 cycles accept->out_valid on key miss, 11 on key-cache hit.
// Backpressure: one block in flight; in_ready low until the result is taken via out_ready.
// Ports: clk, reset (async active-high), io (aes128_decrypt_iter_if.slave).

package aes128_dec_pkg;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction
endpackage

// Forward S-box: affine(inverse(a)).
module sbox
  import aes128_dec_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] b;
  assign b = ginv(a);
  assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse(inverse_affine(a)).
module inv_sbox
  import aes128_dec_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] t;
  assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  assign y = ginv(t);
endmodule

module aes128_decrypt_iter
  import aes128_dec_pkg::*;
#(
  parameter int KEY_CACHE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  aes128_decrypt_iter_if.slave  io
);
  typedef enum logic [2:0] {IDLE, KEXP, ARK, ROUND, FINAL, DONE} state_t;

  state_t       fsm;
  logic [127:0] st;
  logic [127:0] pt_q;
  logic [127:0] rk [0:10];
  logic [3:0]   cnt;
  logic         cache_valid;
  logic         ov;

  // Shared InvSubBytes(InvShiftRows(st)), used by both ROUND and FINAL.
  logic [127:0] isb;
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 4*c + r;
      localparam int SRC = 4*((c + 4 - r) % 4) + r;
      inv_sbox u_isb (.a(st[127-8*SRC -: 8]), .y(isb[127-8*DST -: 8]));
    end
  end

  // Key schedule step: rk[cnt] from rk[cnt-1].
  logic [3:0]   kidx;
  logic [127:0] kp;
  logic [31:0]  rot, sw, t, n0, n1, n2, n3;
  logic [7:0]   rc;

  assign kidx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
  assign kp   = rk[kidx];
  assign rot  = {kp[23:0], kp[31:24]};
  for (genvar b = 0; b < 4; b++) begin : g_ksb
    sbox u_sb (.a(rot[31-8*b -: 8]), .y(sw[31-8*b -: 8]));
  end

  always_comb begin
    rc = 8'h00;
    case (cnt)
      4'd1:  rc = 8'h01;
      4'd2:  rc = 8'h02;
      4'd3:  rc = 8'h04;
      4'd4:  rc = 8'h08;
      4'd5:  rc = 8'h10;
      4'd6:  rc = 8'h20;
      4'd7:  rc = 8'h40;
      4'd8:  rc = 8'h80;
      4'd9:  rc = 8'h1b;
      4'd10: rc = 8'h36;
      default: rc = 8'h00;
    endcase
  end

  assign t  = sw ^ {rc, 24'h000000};
  assign n0 = kp[127:96] ^ t;
  assign n1 = kp[95:64]  ^ n0;
  assign n2 = kp[63:32]  ^ n1;
  assign n3 = kp[31:0]   ^ n2;

  // Compared against rk[0] before this accept overwrites it.
  logic hit;
  assign hit = (KEY_CACHE != 0) && cache_valid && (io.key == rk[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm         <= IDLE;
      st          <= '0;
      pt_q        <= '0;
      cnt         <= '0;
      cache_valid <= 1'b0;
      ov          <= 1'b0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (io.in_valid) begin
            st    <= io.ciphertext;
            rk[0] <= io.key;
            if (hit) begin
              fsm <= ARK;
            end else begin
              cache_valid <= 1'b0;
              cnt         <= 4'd1;
              fsm         <= KEXP;
            end
          end
        end
        KEXP: begin
          rk[cnt] <= {n0, n1, n2, n3};
          if (cnt == 4'd10) begin
            cache_valid <= 1'b1;
            fsm         <= ARK;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ARK: begin
          st  <= st ^ rk[10];
          cnt <= 4'd9;
          fsm <= ROUND;
        end
        ROUND: begin
          st  <= inv_mix(isb ^ rk[cnt]);
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) fsm <= FINAL;
        end
        FINAL: begin
          pt_q <= isb ^ rk[0];
          ov   <= 1'b1;
          fsm  <= DONE;
        end
        DONE: begin
          if (io.out_ready) begin
            ov  <= 1'b0;
            fsm <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (fsm == IDLE);
  assign io.busy      = (fsm != IDLE);
  assign io.out_valid = ov;
  assign io.plaintext = pt_q;
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: known-answer vectors, backpressure, mid-run reset,
// and random encrypt->decrypt round trips against a byte-level AES reference.
module tb_aes128_decrypt_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes128_decrypt_iter_if ifa ();
  aes128_decrypt_iter_if ifb ();

  aes128_decrypt_iter #(.KEY_CACHE(1)) dut_c (.clk(clk), .reset(rst), .io(ifa.slave));
  aes128_decrypt_iter #(.KEY_CACHE(0)) dut_n (.clk(clk), .reset(rst), .io(ifb.slave));

  // Index 0 drives the caching core, index 1 the non-caching core.
  logic         iv [2];
  logic         ordy [2];
  logic [127:0] kk [2];
  logic [127:0] cc [2];
  logic         ov [2];
  logic         ir [2];
  logic         bz [2];
  logic [127:0] pp [2];

  assign ifa.in_valid   = iv[0];
  assign ifa.out_ready  = ordy[0];
  assign ifa.key        = kk[0];
  assign ifa.ciphertext = cc[0];
  assign ifb.in_valid   = iv[1];
  assign ifb.out_ready  = ordy[1];
  assign ifb.key        = kk[1];
  assign ifb.ciphertext = cc[1];
  assign ov[0] = ifa.out_valid;
  assign ir[0] = ifa.in_ready;
  assign bz[0] = ifa.busy;
  assign pp[0] = ifa.plaintext;
  assign ov[1] = ifb.out_valid;
  assign ir[1] = ifb.in_ready;
  assign bz[1] = ifb.busy;
  assign pp[1] = ifb.plaintext;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 0) begin
      if (y[0]) p ^= x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b, s;
    logic [7:0] cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ cst[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] m_rk(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcv = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcv, 24'h0};
        rcv = m_mul(rcv, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] m_enc(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a [4];
    logic [127:0] v;
    v = p ^ m_rk(k, 0);
    for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) u[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = u[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
          for (int r = 0; r < 4; r++)
            s[4*c+r] = m_mul(a[r], 8'h02) ^ m_mul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      end
      v = m_rk(k, rnd);
      for (int i = 0; i < 16; i++) s[i] ^= v[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
    return v;
  endfunction

  // ---------------- drivers ----------------
  // Presents one block, returns plaintext and edges from accept to out_valid.
  task automatic run_block(input int s, input logic [127:0] k, input logic [127:0] c,
                           output logic [127:0] p, output int lat);
    int n = 0;
    @(negedge clk);
    kk[s] = k; cc[s] = c; iv[s] = 1'b1;
    while (!ir[s] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    iv[s] = 1'b0;
    lat = 0;
    while (!ov[s] && lat < 200) begin @(posedge clk); #1; lat++; end
    p = pp[s];
  endtask

  typedef struct {
    int           sel;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         vt [5];
    logic [127:0] p, k, c, pt, mkey;
    int           lat, bad_v, bad_p, bad_r, explat;
    logic         mvalid;

    vt[0] = '{0, K1, C1, P1, 21};   // cold cache
    vt[1] = '{0, K1, C1, P1, 11};   // same key: cache hit
    vt[2] = '{1, K1, C1, P1, 21};   // no cache: always expands
    vt[3] = '{1, K1, C1, P1, 21};
    vt[4] = '{0, K2, C2, P2, 21};   // key changed

    build_sbox();
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; ordy[s] = 1'b1; kk[s] = '0; cc[s] = '0;
    end
    rst = 1'b1;
    #12;
    chk("reset in_ready", 128'(ir[0]), 128'd1);
    chk("reset busy", 128'(bz[0]), 128'd0);
    chk("reset out_valid", 128'(ov[0]), 128'd0);
    chk("reset plaintext", pp[0], 128'd0);
    @(negedge clk); rst = 1'b0;

    // Known-answer table.
    for (int i = 0; i < 5; i++) begin
      run_block(vt[i].sel, vt[i].key, vt[i].ct, p, lat);
      chk($sformatf("vec%0d plaintext", i), p, vt[i].pt);
      chk($sformatf("vec%0d latency", i), 128'(lat), 128'(vt[i].lat));
      @(posedge clk); #1;
      chk($sformatf("vec%0d idle after take", i), 128'({ir[vt[i].sel], ov[vt[i].sel]}), 128'b10);
    end

    // Backpressure: hold result 15 cycles while unrelated requests are offered.
    ordy[0] = 1'b0;
    run_block(0, K2, C2, p, lat);
    chk("bp latency", 128'(lat), 128'd11);
    chk("bp plaintext", p, P2);
    bad_v = 0; bad_p = 0; bad_r = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      iv[0] = j[0];
      kk[0] = {$urandom, $urandom, $urandom, $urandom};
      cc[0] = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      if (ov[0] !== 1'b1) bad_v++;
      if (pp[0] !== P2) bad_p++;
      if (ir[0] !== 1'b0) bad_r++;
    end
    chk("bp out_valid held", 128'(bad_v), 128'd0);
    chk("bp plaintext stable", 128'(bad_p), 128'd0);
    chk("bp in_ready low", 128'(bad_r), 128'd0);
    @(negedge clk); iv[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp release idle", 128'({ir[0], ov[0]}), 128'b10);
    run_block(0, K2, C2, p, lat);
    chk("bp cache kept latency", 128'(lat), 128'd11);
    chk("bp cache kept plaintext", p, P2);
    @(posedge clk); #1;

    // Mid-round reset on a cached key, then the cache must be cold.
    run_block(0, K1, C1, p, lat);
    chk("rst warm latency", 128'(lat), 128'd21);
    @(posedge clk); #1;
    @(negedge clk); kk[0] = K1; cc[0] = C1; iv[0] = 1'b1;
    @(posedge clk); #1; iv[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("rst busy before", 128'({bz[0], ov[0]}), 128'b10);
    #2 rst = 1'b1;
    #1;
    chk("rst out_valid", 128'(ov[0]), 128'd0);
    chk("rst plaintext", pp[0], 128'd0);
    chk("rst in_ready", 128'(ir[0]), 128'd1);
    chk("rst busy", 128'(bz[0]), 128'd0);
    @(negedge clk); rst = 1'b0;
    run_block(0, K1, C1, p, lat);
    chk("post-rst latency", 128'(lat), 128'd21);
    chk("post-rst plaintext", p, P1);
    @(posedge clk); #1;

    // Random round trips through the reference encryptor.
    mkey = K1; mvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(3) == 0) k = mkey;
      else k = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      c  = m_enc(k, pt);
      explat = (mvalid && k == mkey) ? 11 : 21;
      run_block(0, k, c, p, lat);
      chk($sformatf("rt%0d plaintext", i), p, pt);
      chk($sformatf("rt%0d latency", i), 128'(lat), 128'(explat));
      mkey = k; mvalid = 1'b1;
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
